multilane_8b10b_tx: RTL and testbench
=====================================

Name: multilane_8b10b_tx

Overview:
- Parametrised N-lane 8b/10b serial transmitter for breakout-to-host links.
- Each lane sends a fixed-length frame: one comma header symbol followed by NUM_BYTES data symbols, one bit per i_clk.
- Lane start times are staggered evenly across one frame period, so a shared input sampled by all lanes reaches the host NUM_LANES times per frame.
- New relative to the fixed two-lane sender: sync-header insertion, per-lane enable with idle frames, and internal word latching.
- Sits between the port/button/power sampling logic and the output pad buffers. Pad and clock-forwarding primitives stay outside this block.

Parameters:
- NUM_LANES, 2, number of serial lanes (1..8)
- NUM_BYTES, 2, data bytes per frame (1..4)
- START_DELAY, 5, cycles after reset release before lane 0 starts
- SYNC_PERIOD, 16, one frame in every SYNC_PERIOD uses the sync header; 0 disables sync headers

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_reset_n  in  1  synchronous, active-low reset
- i_data  in  NUM_LANES*NUM_BYTES*8  flattened lane words; lane k uses bits [(k+1)*NUM_BYTES*8-1 : k*NUM_BYTES*8]
- i_lane_en  in  NUM_LANES  per-lane enable, sampled at each frame load
- o_data_read  out  NUM_LANES  one-cycle pulse: lane k latched its word slice on this edge
- o_serial  out  NUM_LANES  serial bit stream per lane
- o_sync  out  NUM_LANES  high for the 10 cycles in which lane k's sync header is on the wire

Behaviour:
- Derived constants:
  - FRAME_BITS = 10*(NUM_BYTES+1)
  - STAGGER = floor(FRAME_BITS/NUM_LANES)
  - START_k = START_DELAY + k*STAGGER
- Reset (i_reset_n=0 on an edge):
  - o_serial=0, o_data_read=0, o_sync=0.
  - Start counter cleared; running disparity (RD) of every lane set to RD-; frame counters cleared; all lanes go to HOLD.
  - Reset is effective mid-frame: the output drops to 0 on the next edge and the partial frame is abandoned.
- Start counter:
  - Counts cycles from the first edge with i_reset_n=1 and saturates at START_(NUM_LANES-1).
  - Lane k leaves HOLD at count START_k.
- Per-lane states:
  - HOLD: o_serial=0.
  - LOAD: exactly one cycle.
    - Sample i_lane_en[k].
    - If enabled: latch the lane word and pulse o_data_read[k]=1.
    - Select the header: K28.1 when frame_count % SYNC_PERIOD == 0 and SYNC_PERIOD != 0; otherwise K28.5.
  - SEND: symbols go out in order header, byte0 (LSB byte), byte1, ... Within each symbol, bit order is a,b,c,d,e,i,f,g,h,j.
- Frame timing:
  - The first LOAD cycle coincides with the last HOLD cycle. The first header bit appears on the cycle after it.
  - After that, LOAD coincides with bit FRAME_BITS-1 of the current frame, so frames are gap-free with period exactly FRAME_BITS.
  - o_data_read[k] therefore pulses every FRAME_BITS cycles.
  - Latch-to-first-data-bit latency is 11 cycles.
- Encoding:
  - Standard 8b/10b with RD tracked per lane across all symbols, including headers and idle symbols.
  - Any internal encoding pipeline is hidden: the output timing above is normative.
- Disabled lane (i_lane_en[k]=0 at LOAD):
  - The whole frame is K28.5 symbols.
  - No o_data_read pulse; the latched word is unchanged.
  - frame_count still advances. The sync header still replaces K28.5 in the header slot when it is due.
- i_lane_en changes mid-frame have no effect until the next LOAD.
- frame_count wraps modulo SYNC_PERIOD; the first frame after reset is a sync frame.
- o_sync is aligned exactly with the header bits of sync frames.
- With NUM_LANES=1, STAGGER = FRAME_BITS and only lane 0 exists.
- Non-integer FRAME_BITS/NUM_LANES uses the floor for STAGGER; the residual skew is accepted.

Test Plan:
- NUM_LANES=2, NUM_BYTES=2, release reset at cycle 0 -> o_data_read[0] at count 5 and [1] at count 20; both then repeat every 30 cycles; o_serial stays 0 before each lane starts.
- Lane 0 word 0x0000, first frame -> 0011111001 (K28.1 RD-) then 0110001011 0110001011 (D0.0 RD+, D0.0 RD+); o_sync[0] high during the first 10 bits only.
- Second frame, same word -> header 1100000101 (K28.5 RD+); no o_sync; decoded data 0x0000; the checker's RD stays consistent.
- Random words over 200 frames on all lanes -> a reference decoder recovers every latched word with no disparity or code errors; sync header every 16th frame.
- Clear i_lane_en[1] mid-frame -> the current frame completes normally; the next frame is all K28.5; no o_data_read[1] pulse; re-enable -> data resumes at the following LOAD.
- Assert i_reset_n=0 at bit 13 of a frame -> o_serial=0 on the next edge; after release, timing restarts from count 0 and the first frame uses a sync header at RD-.

Source files
------------

// File: rtl/multilane_8b10b_tx.sv
// N-lane 8b/10b serial transmitter: each lane sends gap-free frames of one comma
// header plus NUM_BYTES data symbols, one bit per clock, with staggered lane starts.
module multilane_8b10b_tx #(
    parameter int unsigned NUM_LANES   = 2,
    parameter int unsigned NUM_BYTES   = 2,
    parameter int unsigned START_DELAY = 5,
    parameter int unsigned SYNC_PERIOD = 16
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [NUM_LANES*NUM_BYTES*8-1:0] i_data,
    input  logic [NUM_LANES-1:0]             i_lane_en,
    output logic [NUM_LANES-1:0]             o_data_read,
    output logic [NUM_LANES-1:0]             o_serial,
    output logic [NUM_LANES-1:0]             o_sync
);
    localparam int unsigned FRAME_BITS = 10 * (NUM_BYTES + 1);
    localparam int unsigned STAGGER    = FRAME_BITS / NUM_LANES;
    localparam int unsigned LAST_START = START_DELAY + (NUM_LANES - 1) * STAGGER;
    localparam int unsigned CNT_W      = $clog2(LAST_START + 2);
    localparam int unsigned SYM_W      = $clog2(NUM_BYTES + 1);
    localparam int unsigned FC_W       = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam int unsigned WORD_W     = NUM_BYTES * 8;
    localparam logic [7:0]  K28_1      = 8'h3C;
    localparam logic [7:0]  K28_5      = 8'hBC;

    typedef enum logic {HOLD, SEND} lane_state_e;

    lane_state_e          state_q [NUM_LANES];
    logic [3:0]           pos_q   [NUM_LANES];
    logic [SYM_W-1:0]     sym_q   [NUM_LANES];
    logic [FC_W-1:0]      frame_q [NUM_LANES];
    logic [WORD_W-1:0]    word_q  [NUM_LANES];
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_LANES-1:0] en_q, hdr_sync_q, rd_q;
    logic [NUM_LANES-1:0] read_q, serial_q, sync_out_q;

    logic [7:0]           sym_byte_c [NUM_LANES];
    logic [NUM_LANES-1:0] sym_k_c, load_c;
    logic [10:0]          enc_c      [NUM_LANES];

    // Returns {rd_after, abcdei, fghj} for one symbol at running disparity rd (1 = RD+).
    function automatic logic [10:0] encode(input logic [7:0] d, input logic k, input logic rd);
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd6;
        logic       a7;
        case (d[4:0])
            5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;  5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
            5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;  5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
            5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;  5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
            5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;  5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
            5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;  5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
            5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;  5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
            5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;  5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
            5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;  5'd30: c6 = 6'b011110;  default: c6 = 6'b101011;
        endcase
        if (k) c6 = 6'b001111;
        if (rd && (($countones(c6) != 3) || (c6 == 6'b111000))) c6 = ~c6;
        rd6 = rd ^ ($countones(c6) != 3);
        a7  = rd6 ? (d[4:0] inside {5'd11, 5'd13, 5'd14}) : (d[4:0] inside {5'd17, 5'd18, 5'd20});
        case (d[7:5])
            3'd0:    c4 = 4'b1011;
            3'd1:    c4 = k ? 4'b0110 : 4'b1001;
            3'd2:    c4 = 4'b0101;
            3'd3:    c4 = 4'b1100;
            3'd4:    c4 = 4'b1101;
            3'd5:    c4 = k ? 4'b0101 : 4'b1010;
            3'd6:    c4 = 4'b0110;
            default: c4 = a7 ? 4'b0111 : 4'b1110;
        endcase
        if (rd6 && (($countones(c4) != 2) || (c4 == 4'b1100) || k)) c4 = ~c4;
        return {rd6 ^ ($countones(c4) != 2), c6, c4};
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            sym_byte_c[k] = K28_5;
            sym_k_c[k]    = 1'b1;
            if (sym_q[k] == '0) begin
                if (hdr_sync_q[k]) sym_byte_c[k] = K28_1;
            end else if (en_q[k]) begin
                sym_byte_c[k] = word_q[k][8*(int'(sym_q[k]) - 1) +: 8];
                sym_k_c[k]    = 1'b0;
            end
            enc_c[k]  = encode(sym_byte_c[k], sym_k_c[k], rd_q[k]);
            // A frame load overlaps the last HOLD cycle or the last bit of the running frame.
            load_c[k] = ((state_q[k] == HOLD) && (cnt_q == CNT_W'(START_DELAY + k * STAGGER))) ||
                        ((state_q[k] == SEND) && (sym_q[k] == SYM_W'(NUM_BYTES)) && (pos_q[k] == 4'd9));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_q      <= '0;
            en_q       <= '0;
            hdr_sync_q <= '0;
            rd_q       <= '0;
            read_q     <= '0;
            serial_q   <= '0;
            sync_out_q <= '0;
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                state_q[k] <= HOLD;
                pos_q[k]   <= '0;
                sym_q[k]   <= '0;
                frame_q[k] <= '0;
                word_q[k]  <= '0;
            end
        end else begin
            if (cnt_q != CNT_W'(LAST_START)) cnt_q <= cnt_q + 1'b1;
            read_q <= '0;
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                serial_q[k]   <= 1'b0;
                sync_out_q[k] <= 1'b0;
                if (state_q[k] == SEND) begin
                    serial_q[k]   <= enc_c[k][4'd9 - pos_q[k]];
                    sync_out_q[k] <= hdr_sync_q[k] && (sym_q[k] == '0);
                    if (pos_q[k] == 4'd9) begin
                        pos_q[k] <= '0;
                        sym_q[k] <= sym_q[k] + 1'b1;
                        rd_q[k]  <= enc_c[k][10];
                    end else begin
                        pos_q[k] <= pos_q[k] + 1'b1;
                    end
                end
                if (load_c[k]) begin
                    state_q[k]    <= SEND;
                    pos_q[k]      <= '0;
                    sym_q[k]      <= '0;
                    en_q[k]       <= i_lane_en[k];
                    hdr_sync_q[k] <= (SYNC_PERIOD != 0) && (frame_q[k] == '0);
                    if (SYNC_PERIOD > 1)
                        frame_q[k] <= (frame_q[k] == FC_W'(SYNC_PERIOD - 1)) ? '0 : frame_q[k] + 1'b1;
                    if (i_lane_en[k]) begin
                        word_q[k] <= i_data[k*WORD_W +: WORD_W];
                        read_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_data_read = read_q;
    assign o_serial    = serial_q;
    assign o_sync      = sync_out_q;
endmodule

// File: tb/tb_multilane_8b10b_tx.sv
// Scoreboard bench for multilane_8b10b_tx: frames are queued at each predicted load
// and checked against a reference 8b/10b decoder when the lane finishes sending them.
module tb_multilane_8b10b_tx;
    localparam int NL = 2;
    localparam int NB = 2;
    localparam int SD = 5;
    localparam int SP = 16;
    localparam int FB = 10 * (NB + 1);
    localparam int ST = FB / NL;
    localparam int EN_OFF = SD + ST + 50 * FB + 13;
    localparam int EN_ON  = SD + ST + 52 * FB + 7;
    localparam logic [9:0] K281N = 10'b0011111001, K281P = 10'b1100000110;
    localparam logic [9:0] K285N = 10'b0011111010, K285P = 10'b1100000101;

    typedef logic [NB*8-1:0] word_t;
    typedef struct packed {word_t word; logic en; logic sync;} frame_t;

    logic                clk = 1'b0;
    logic                i_reset_n = 1'b0;
    logic [NL*NB*8-1:0]  i_data = '0;
    logic [NL-1:0]       i_lane_en = '1;
    logic [NL-1:0]       o_data_read, o_serial, o_sync;

    frame_t     sb [NL][$];
    int         n_checks = 0, n_fails = 0, t = 0;
    int         fidx [NL];
    int         done_cnt [NL];
    logic [NL-1:0] brd, load_en;
    logic [9:0] sh [NL];
    logic [9:0] syms [NL][NB+1];

    always #5 clk = ~clk;

    multilane_8b10b_tx #(.NUM_LANES(NL), .NUM_BYTES(NB), .START_DELAY(SD), .SYNC_PERIOD(SP)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_data(i_data), .i_lane_en(i_lane_en),
        .o_data_read(o_data_read), .o_serial(o_serial), .o_sync(o_sync));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Returns {code_error, rd_after, byte}.
    function automatic logic [9:0] ref_decode(input logic [9:0] c, input logic rd);
        logic [5:0] s6;
        logic [3:0] s4;
        logic [4:0] x;
        logic [2:0] y;
        logic err, r, alt;
        s6 = c[9:4]; s4 = c[3:0]; x = '0; y = '0; err = 1'b0; r = rd;
        case ($countones(s6))
            3: if ((s6 == 6'b111000 && r) || (s6 == 6'b000111 && !r)) err = 1'b1;
            4: if (r) err = 1'b1; else r = 1'b1;
            2: if (!r) err = 1'b1; else r = 1'b0;
            default: err = 1'b1;
        endcase
        case (s6)
            6'b100111, 6'b011000: x = 5'd0;   6'b011101, 6'b100010: x = 5'd1;
            6'b101101, 6'b010010: x = 5'd2;   6'b110001:            x = 5'd3;
            6'b110101, 6'b001010: x = 5'd4;   6'b101001:            x = 5'd5;
            6'b011001:            x = 5'd6;   6'b111000, 6'b000111: x = 5'd7;
            6'b111001, 6'b000110: x = 5'd8;   6'b100101:            x = 5'd9;
            6'b010101:            x = 5'd10;  6'b110100:            x = 5'd11;
            6'b001101:            x = 5'd12;  6'b101100:            x = 5'd13;
            6'b011100:            x = 5'd14;  6'b010111, 6'b101000: x = 5'd15;
            6'b011011, 6'b100100: x = 5'd16;  6'b100011:            x = 5'd17;
            6'b010011:            x = 5'd18;  6'b110010:            x = 5'd19;
            6'b001011:            x = 5'd20;  6'b101010:            x = 5'd21;
            6'b011010:            x = 5'd22;  6'b111010, 6'b000101: x = 5'd23;
            6'b110011, 6'b001100: x = 5'd24;  6'b100110:            x = 5'd25;
            6'b010110:            x = 5'd26;  6'b110110, 6'b001001: x = 5'd27;
            6'b001110:            x = 5'd28;  6'b101110, 6'b010001: x = 5'd29;
            6'b011110, 6'b100001: x = 5'd30;  6'b101011, 6'b010100: x = 5'd31;
            default: err = 1'b1;
        endcase
        alt = r ? (x == 5'd11 || x == 5'd13 || x == 5'd14) : (x == 5'd17 || x == 5'd18 || x == 5'd20);
        case ($countones(s4))
            2: if ((s4 == 4'b1100 && r) || (s4 == 4'b0011 && !r)) err = 1'b1;
            3: if (r) err = 1'b1; else r = 1'b1;
            1: if (!r) err = 1'b1; else r = 1'b0;
            default: err = 1'b1;
        endcase
        case (s4)
            4'b1011, 4'b0100: y = 3'd0;
            4'b1001:          y = 3'd1;
            4'b0101:          y = 3'd2;
            4'b1100, 4'b0011: y = 3'd3;
            4'b1101, 4'b0010: y = 3'd4;
            4'b1010:          y = 3'd5;
            4'b0110:          y = 3'd6;
            4'b1110, 4'b0001: begin y = 3'd7; if (alt) err = 1'b1; end
            4'b0111, 4'b1000: begin y = 3'd7; if (!alt) err = 1'b1; end
            default: err = 1'b1;
        endcase
        return {err, r, y, x};
    endfunction

    task automatic finish_frame(input int k);
        frame_t f;
        logic [9:0] r;
        f = sb[k].pop_front();
        if (k == 0 && done_cnt[k] == 0) begin
            check("f0_hdr", syms[k][0], 10'b0011111001);
            check("f0_d0", syms[k][1], 10'b0110001011);
            check("f0_d1", syms[k][2], 10'b0110001011);
        end
        if (k == 0 && done_cnt[k] == 1) begin
            check("f1_hdr", syms[k][0], 10'b1100000101);
            check("f1_d0", syms[k][1], 10'b1001110100);
            check("f1_d1", syms[k][2], 10'b1001110100);
        end
        check("header", syms[k][0], f.sync ? (brd[k] ? K281P : K281N) : (brd[k] ? K285P : K285N));
        brd[k] = ~brd[k];
        for (int b = 0; b < NB; b++) begin
            if (f.en) begin
                r = ref_decode(syms[k][b+1], brd[k]);
                check("code_err", r[9], 1'b0);
                check("byte", r[7:0], f.word[b*8 +: 8]);
                brd[k] = r[8];
            end else begin
                check("idle", syms[k][b+1], brd[k] ? K285P : K285N);
                brd[k] = ~brd[k];
            end
        end
        done_cnt[k]++;
    endtask

    task automatic monitor(input int te);
        for (int k = 0; k < NL; k++) begin
            int s, bp;
            logic er;
            s  = SD + k * ST;
            er = (te >= s) && ((te - s) % FB == 0) && load_en[k];
            check("data_read", o_data_read[k], er);
            if (te <= s) begin
                check("serial_idle", o_serial[k], 1'b0);
                check("sync_idle", o_sync[k], 1'b0);
            end else if (sb[k].size() == 0) begin
                check("sb_underflow", sb[k].size(), 1);
            end else begin
                bp = (te - s - 1) % FB;
                check("sync", o_sync[k], sb[k][0].sync && (bp < 10));
                sh[k] = {sh[k][8:0], o_serial[k]};
                if (bp % 10 == 9) syms[k][bp/10] = sh[k];
                if (bp == FB - 1) finish_frame(k);
            end
        end
    endtask

    task automatic drive(input int td);
        word_t w;
        frame_t f;
        i_reset_n = 1'b1;
        i_lane_en = '1;
        if (td >= EN_OFF && td < EN_ON) i_lane_en[1] = 1'b0;
        for (int k = 0; k < NL; k++) begin
            w = word_t'($urandom());
            if (k == 0 && td <= SD + FB) w = '0;
            i_data[k*NB*8 +: NB*8] = w;
            load_en[k] = 1'b0;
            if (td >= SD + k * ST && (td - SD - k * ST) % FB == 0) begin
                load_en[k] = i_lane_en[k];
                f.word = w;
                f.en   = i_lane_en[k];
                f.sync = (fidx[k] % SP == 0);
                sb[k].push_back(f);
                fidx[k]++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (t > 0) monitor(t - 1);
            drive(t);
            t++;
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            i_reset_n = 1'b0;
            i_lane_en = '1;
            i_data    = '1;
            @(posedge clk);
            #1;
            check("rst_serial", o_serial, '0);
            check("rst_read", o_data_read, '0);
            check("rst_sync", o_sync, '0);
        end
        t = 0; brd = '0; load_en = '0;
        for (int k = 0; k < NL; k++) begin
            sb[k].delete();
            fidx[k] = 0;
            done_cnt[k] = 0;
            sh[k] = '0;
        end
    endtask

    initial begin
        do_reset(3);
        // Ends with lane 0 showing bit 13 of a frame, so the next reset lands mid-frame.
        run(6320);
        do_reset(2);
        run(100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
